// File: rtl/averager_scheduler.sv
// -----------------------------------------------------------------------------
// averager_scheduler
//   Time-shares one external averager across N_CHANNELS ADC channels. A
//   round-robin scheduler picks the next enabled channel with a non-zero
//   averaging count. It pulses the averager clear, streams that channel's
//   samples into the averager, and republishes the averager result together
//   with the channel index.
//
// Ports
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   enable           : keeps the service loop running
//   channel_mask     : bit i set -> channel i is serviced
//   points_cfg       : per-channel averaging count, slice i for channel i
//   ch_data          : per-channel signed sample buses, slice i for channel i
//   avg_data_in      : selected sample to the averager (0 outside RUN)
//   avg_points       : averaging count latched for the current channel
//   avg_run          : averager run enable (high only in RUN)
//   avg_clear        : one-cycle averager clear pulse (CLEAR state)
//   avg_data_out     : averager result
//   avg_data_valid   : averager result strobe (honoured only in RUN)
//   result_data      : published average
//   result_channel   : channel index of result_data
//   result_valid     : one-cycle strobe for result_data/result_channel
//   busy             : high in any state other than IDLE
//   state_dbg        : current FSM state encoding, for observation
//   timeout_err      : sticky RUN watchdog flag (AVG_SCHED_TIMEOUT_EN only)
//
// Handshake: the averager result is accepted in the single RUN cycle in which
// avg_data_valid is high; result_valid is a one-cycle strobe with no back-
// pressure. Downstream logic must capture it in that cycle.
//
// Optional feature: define AVG_SCHED_TIMEOUT_EN to add the RUN watchdog and
// the timeout_err output. Without it, RUN waits indefinitely for the strobe.
// -----------------------------------------------------------------------------
module averager_scheduler #(
   parameter int N_CHANNELS     = 4,
   parameter int DATA_BITS      = 32,
   parameter int AVG_BITS       = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int CH_W          = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [N_CHANNELS-1:0]           channel_mask,
   input  logic [N_CHANNELS*AVG_BITS-1:0]  points_cfg,
   input  logic [N_CHANNELS*DATA_BITS-1:0] ch_data,
   output logic [DATA_BITS-1:0]            avg_data_in,
   output logic [AVG_BITS-1:0]             avg_points,
   output logic                            avg_run,
   output logic                            avg_clear,
   input  logic [DATA_BITS-1:0]            avg_data_out,
   input  logic                            avg_data_valid,
   output logic [DATA_BITS-1:0]            result_data,
   output logic [CH_W-1:0]                 result_channel,
   output logic                            result_valid,
   output logic                            busy,
   output logic [2:0]                      state_dbg
`ifdef AVG_SCHED_TIMEOUT_EN
   ,output logic                           timeout_err
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_CLEAR   = 3'd2,
      ST_RUN     = 3'd3,
      ST_PUBLISH = 3'd4
   } state_t;

   state_t          state_q;
   logic [CH_W-1:0] last_ch_q;
   logic [CH_W-1:0] cur_ch_q;

   // Unpack the flat configuration and data buses into per-channel arrays.
   logic [AVG_BITS-1:0]  pts_arr [N_CHANNELS];
   logic [DATA_BITS-1:0] dat_arr [N_CHANNELS];

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_unpack
      assign pts_arr[g] = points_cfg[g*AVG_BITS +: AVG_BITS];
      assign dat_arr[g] = ch_data[g*DATA_BITS +: DATA_BITS];
   end

   // Round-robin search starting at last_ch+1. The candidate index is stepped
   // with an explicit wrap so that non-power-of-two channel counts never
   // address a missing channel.
   logic            sel_found_d;
   logic [CH_W-1:0] sel_ch_d;
   logic [CH_W-1:0] cand;

   always_comb begin
      sel_found_d = 1'b0;
      sel_ch_d    = '0;
      cand        = last_ch_q;
      for (int k = 0; k < N_CHANNELS; k++) begin
         if (cand == CH_W'(N_CHANNELS - 1)) cand = '0;
         else                               cand = cand + 1'b1;
         if (!sel_found_d && channel_mask[cand] && (pts_arr[cand] != '0)) begin
            sel_found_d = 1'b1;
            sel_ch_d    = cand;
         end
      end
   end

   // The sample path is combinational so the averager sees the live sample
   // from the first RUN cycle; it is forced to 0 in every other state.
   assign avg_data_in = (state_q == ST_RUN) ? dat_arr[cur_ch_q] : '0;
   assign busy        = (state_q != ST_IDLE);
   assign state_dbg   = state_q;

`ifdef AVG_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] run_cnt_q;
   logic            timeout_hit;
   // run_cnt_q counts completed RUN cycles; the watchdog fires at the end of
   // the TIMEOUT_CYCLES-th RUN cycle.
   assign timeout_hit = (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   // TIMEOUT_CYCLES only matters when the watchdog is compiled in.
   if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         last_ch_q      <= CH_W'(N_CHANNELS - 1);
         cur_ch_q       <= '0;
         avg_points     <= '0;
         avg_run        <= 1'b0;
         avg_clear      <= 1'b0;
         result_data    <= '0;
         result_channel <= '0;
         result_valid   <= 1'b0;
`ifdef AVG_SCHED_TIMEOUT_EN
         run_cnt_q      <= '0;
         timeout_err    <= 1'b0;
`endif
      end else begin
         avg_clear    <= 1'b0;
         result_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable && (|channel_mask)) state_q <= ST_SELECT;
            end
            ST_SELECT: begin
               if (sel_found_d) begin
                  cur_ch_q   <= sel_ch_d;
                  // Held until the next CLEAR so later points_cfg edits do
                  // not disturb an average in progress.
                  avg_points <= pts_arr[sel_ch_d];
                  avg_clear  <= 1'b1;
                  state_q    <= ST_CLEAR;
               end else begin
                  state_q    <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               avg_run <= 1'b1;
`ifdef AVG_SCHED_TIMEOUT_EN
               run_cnt_q <= '0;
`endif
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (avg_data_valid) begin
                  result_data    <= avg_data_out;
                  result_channel <= cur_ch_q;
                  result_valid   <= 1'b1;
                  avg_run        <= 1'b0;
                  state_q        <= ST_PUBLISH;
               end
`ifdef AVG_SCHED_TIMEOUT_EN
               else if (timeout_hit) begin
                  // Abandon this channel without publishing; move on.
                  avg_run     <= 1'b0;
                  timeout_err <= 1'b1;
                  last_ch_q   <= cur_ch_q;
                  state_q     <= ST_SELECT;
               end else begin
                  run_cnt_q <= run_cnt_q + 1'b1;
               end
`endif
            end
            ST_PUBLISH: begin
               last_ch_q <= cur_ch_q;
               state_q   <= enable ? ST_SELECT : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_averager_scheduler.sv
// -----------------------------------------------------------------------------
// tb_averager_scheduler
//   Bench for averager_scheduler with a behavioural averager model, a
//   round-robin expectation model and an expected-result queue that a monitor
//   drains whenever result_valid is seen.
// -----------------------------------------------------------------------------
module tb_averager_scheduler;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 8;
`ifdef AVG_SCHED_TIMEOUT_EN
   localparam int TO_CYC = 64;
`else
   localparam int TO_CYC = 4096;
`endif

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic            enable = 1'b0;
   logic [N-1:0]    channel_mask = '0;
   logic [N*AW-1:0] points_cfg = '0;
   logic [N*DW-1:0] ch_data = '0;
   logic [DW-1:0]   avg_data_in;
   logic [AW-1:0]   avg_points;
   logic            avg_run;
   logic            avg_clear;
   logic [DW-1:0]   avg_data_out;
   logic            avg_data_valid;
   logic [DW-1:0]   result_data;
   logic [1:0]      result_channel;
   logic            result_valid;
   logic            busy;
   logic [2:0]      state_dbg;
`ifdef AVG_SCHED_TIMEOUT_EN
   logic            timeout_err;
`endif

   averager_scheduler #(
      .N_CHANNELS(N), .DATA_BITS(DW), .AVG_BITS(AW), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .channel_mask(channel_mask), .points_cfg(points_cfg), .ch_data(ch_data),
      .avg_data_in(avg_data_in), .avg_points(avg_points), .avg_run(avg_run),
      .avg_clear(avg_clear), .avg_data_out(avg_data_out),
      .avg_data_valid(avg_data_valid), .result_data(result_data),
      .result_channel(result_channel), .result_valid(result_valid),
      .busy(busy), .state_dbg(state_dbg)
`ifdef AVG_SCHED_TIMEOUT_EN
      ,.timeout_err(timeout_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- averager model ----------------
   // Accumulates avg_points samples after a clear, then strobes the mean.
   longint acc;
   int     cnt;
   logic   mdl_done = 1'b1;
   logic   mdl_valid = 1'b0;
   logic [DW-1:0] mdl_out = '0;
   logic   hold_low = 1'b0;
   logic   force_valid = 1'b0;

   assign avg_data_out   = mdl_out;
   assign avg_data_valid = mdl_valid | force_valid;

   always @(negedge clock) begin
      if (reset) begin
         acc = 0; cnt = 0; mdl_done = 1'b1; mdl_valid = 1'b0;
      end else if (avg_clear) begin
         acc = 0; cnt = 0; mdl_done = 1'b0; mdl_valid = 1'b0;
      end else if (avg_run && !mdl_done && !hold_low) begin
         acc += longint'($signed(avg_data_in));
         cnt++;
         if (cnt == int'(avg_points)) begin
            mdl_out   = DW'(acc / longint'(cnt));
            mdl_valid = 1'b1;
            mdl_done  = 1'b1;
         end else begin
            mdl_valid = 1'b0;
         end
      end else begin
         mdl_valid = 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   // Entry layout: {channel[41:40], points[39:32], data[31:0]}
   logic [41:0] exp_q[$];
   int model_last = N - 1;
   int n_seen = 0;

   // Round-robin rule: next channel after model_last with mask set and
   // non-zero count; the expected average of a constant input is itself.
   task automatic push_expected(input int k);
      for (int r = 0; r < k; r++) begin
         for (int off = 1; off <= N; off++) begin
            int c;
            logic [AW-1:0] p;
            c = (model_last + off) % N;
            p = points_cfg[c*AW +: AW];
            if (channel_mask[c] && p != 0) begin
               exp_q.push_back({2'(c), p, ch_data[c*DW +: DW]});
               model_last = c;
               break;
            end
         end
      end
   endtask

   // ---------------- monitor ----------------
   int   cycle = 0;
   int   clear_cnt = 0;
   int   pub_cycle = 0;
   logic gap_armed = 1'b0;

   always @(negedge clock) begin
      cycle++;
      if (reset) begin
         clear_cnt = 0;
         gap_armed = 1'b0;
      end else begin
         if (!busy) gap_armed = 1'b0;
         if (!avg_run) check("data_in_zero_outside_run", avg_data_in, 0);
         if (avg_clear) begin
            clear_cnt++;
            if (gap_armed) begin
               check("back_to_back_gap", cycle - pub_cycle, 2);
               gap_armed = 1'b0;
            end
            if (exp_q.size() > 0) check("avg_points_at_clear", avg_points, exp_q[0][39:32]);
         end
         if (result_valid) begin
            n_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               logic [41:0] e;
               e = exp_q.pop_front();
               check("result_channel", result_channel, e[41:40]);
               check("result_data", result_data, e[31:0]);
               check("one_clear_per_result", clear_cnt, 1);
            end
            clear_cnt = 0;
            pub_cycle = cycle;
            gap_armed = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_points(input int c, input int v);
      points_cfg[c*AW +: AW] = AW'(v);
   endtask

   task automatic set_data(input int c, input logic [DW-1:0] v);
      ch_data[c*DW +: DW] = v;
   endtask

   task automatic wait_results(input int target, input int limit);
      int n = 0;
      while (n_seen < target && n < limit) begin
         @(negedge clock); #1;
         n++;
      end
      if (n_seen < target) check("wait_results_timeout", n_seen, target);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clock); #1;
         n++;
      end
      check("busy_low_in_idle", busy, 0);
      check("state_idle", state_dbg, 0);
   endtask

   task automatic run_phase(input int k);
      int target;
      target = n_seen + k;
      push_expected(k);
      @(negedge clock); #1;
      enable = 1'b1;
      wait_results(target, 3000);
      enable = 1'b0;
      wait_idle(50);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_avg_run"}, avg_run, 0);
      check({tag, "_avg_clear"}, avg_clear, 0);
      check({tag, "_avg_points"}, avg_points, 0);
      check({tag, "_avg_data_in"}, avg_data_in, 0);
      check({tag, "_result_data"}, result_data, 0);
      check({tag, "_result_channel"}, result_channel, 0);
      check({tag, "_result_valid"}, result_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_state"}, state_dbg, 0);
`ifdef AVG_SCHED_TIMEOUT_EN
      check({tag, "_timeout_err"}, timeout_err, 0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clock); #1;
      reset = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      reset = 1'b0;
      model_last = N - 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clock);
      #1;
      reset = 1'b0;

      // Mask 1011, all counts 16: 0,1,3,0,1,3
      channel_mask = 4'b1011;
      for (int c = 0; c < N; c++) begin
         set_points(c, 16);
         set_data(c, DW'($urandom));
      end
      run_phase(6);

      // Channel 2 has zero count: never chosen
      channel_mask = 4'b1111;
      set_points(2, 0);
      run_phase(3);

      // Constant -323 on channel 0, serviced back-to-back
      channel_mask = 4'b0001;
      set_points(0, 16);
      set_data(0, -DW'(323));
      run_phase(3);

      // Stray strobe while idle must not publish anything
      @(negedge clock); #1;
      force_valid = 1'b1;
      repeat (3) begin
         @(negedge clock); #1;
         check("no_publish_on_idle_strobe", result_valid, 0);
      end
      force_valid = 1'b0;

      // Randomized phases
      for (int p = 0; p < 5; p++) begin
         int first;
         channel_mask = N'($urandom_range(1, (1 << N) - 1));
         for (int c = 0; c < N; c++) begin
            set_points(c, $urandom_range(0, 6));
            set_data(c, DW'($urandom));
         end
         first = 0;
         while (!channel_mask[first]) first++;
         if (points_cfg[first*AW +: AW] == 0) set_points(first, $urandom_range(1, 6));
         run_phase($urandom_range(2, 5));
      end

      // Enable dropped in the 5th RUN cycle: that channel still publishes
      begin
         int rc = 0;
         int lim = 0;
         int target;
         channel_mask = 4'b0101;
         set_points(0, 16);
         set_points(2, 16);
         target = n_seen + 1;
         push_expected(1);
         enable = 1'b1;
         while (rc < 5 && lim < 200) begin
            @(negedge clock); #1;
            lim++;
            if (avg_run) rc++;
         end
         check("reached_5th_run_cycle", rc, 5);
         enable = 1'b0;
         wait_results(target, 200);
         wait_idle(50);
         check("queue_drained_after_drop", exp_q.size(), 0);
      end

      // Reset mid-RUN: outputs clear at once, nothing published
      begin
         int lim = 0;
         channel_mask = 4'b0001;
         set_points(0, 16);
         enable = 1'b1;
         while (!avg_run && lim < 100) begin
            @(negedge clock); #1;
            lim++;
         end
         check("run_before_reset", avg_run, 1);
         repeat (3) @(negedge clock);
         #1;
         reset = 1'b1;
         #1;
         check_reset_outputs("mid_run_reset");
         enable = 1'b0;
         @(negedge clock); #1;
         reset = 1'b0;
         model_last = N - 1;
         repeat (30) begin
            @(negedge clock); #1;
            check("no_result_after_reset", result_valid, 0);
         end
      end

      // After reset the search starts again at channel 0
      channel_mask = 4'b1111;
      for (int c = 0; c < N; c++) set_points(c, 3 + c);
      run_phase(2);

`ifdef AVG_SCHED_TIMEOUT_EN
      // Watchdog: strobe withheld, abandon after 64 RUN cycles
      begin
         int rc = 0;
         int lim = 0;
         do_reset();
         hold_low = 1'b1;
         channel_mask = 4'b0011;
         set_points(0, 5);
         set_points(1, 7);
         set_points(2, 0);
         set_points(3, 0);
         enable = 1'b1;
         while (!avg_clear && lim < 100) begin
            @(negedge clock); #1;
            lim++;
         end
         check("to_first_points", avg_points, 5);
         lim = 0;
         while (!timeout_err && lim < 300) begin
            @(negedge clock); #1;
            lim++;
            if (avg_run) rc++;
         end
         check("to_flag_set", timeout_err, 1);
         check("to_run_cycles", rc, 64);
         lim = 0;
         while (!avg_clear && lim < 100) begin
            @(negedge clock); #1;
            lim++;
         end
         check("to_next_channel_points", avg_points, 7);
         check("to_flag_sticky", timeout_err, 1);
         do_reset();
         #1;
         check("to_flag_cleared_by_reset", timeout_err, 0);
         hold_low = 1'b0;
      end
`endif

      repeat (5) @(negedge clock);
      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/averager_scheduler.md
AVERAGER_SCHEDULER -- requirements
Module: averager_scheduler

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4: number of ADC channels sharing one averager.
REQ-002 SHALL have parameter DATA_BITS, default 32: sample and result width.
REQ-003 SHALL have parameter AVG_BITS, default 8: averaging-count width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit in RUN.
REQ-005 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: high keeps the service loop running.
REQ-008 SHALL have port channel_mask, input, N_CHANNELS: bit i set means channel i is serviced.
REQ-009 SHALL have port points_cfg, input, N_CHANNELS*AVG_BITS: per-channel averaging count; channel i uses slice i.
REQ-010 SHALL have port ch_data, input, N_CHANNELS*DATA_BITS: per-channel sample buses, signed.
REQ-011 SHALL have port avg_data_in, output, DATA_BITS: selected channel sample, to the averager data_in.
REQ-012 SHALL have port avg_points, output, AVG_BITS: to the averager averaging_points.
REQ-013 SHALL have port avg_run, output, 1: to the averager run_averaging.
REQ-014 SHALL have port avg_clear, output, 1: one-cycle clear pulse to the averager reset.
REQ-015 SHALL have port avg_data_out, input, DATA_BITS: averager result.
REQ-016 SHALL have port avg_data_valid, input, 1: averager result strobe.
REQ-017 SHALL have port result_data, output, DATA_BITS: published average.
REQ-018 SHALL have port result_channel, output, $clog2(N_CHANNELS): channel index of result_data.
REQ-019 SHALL have port result_valid, output, 1: one-cycle strobe for result_data and result_channel.
REQ-020 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-021 SHALL implement the FSM IDLE -> SELECT -> CLEAR -> RUN -> PUBLISH -> SELECT.
- IDLE goes to SELECT when enable=1 and channel_mask has any bit set.
REQ-022 SELECT SHALL take one cycle and search round-robin from (last_ch+1) mod N_CHANNELS.
- Picks the first channel with its mask bit set and a non-zero points_cfg slice.
- If no channel qualifies, returns to IDLE.
REQ-023 CLEAR SHALL assert avg_clear for exactly one cycle.
- Latches the chosen channel's points_cfg into avg_points.
- avg_points stays held until the next CLEAR, so later points_cfg changes do not affect the running average.
REQ-024 RUN SHALL hold avg_run=1 and drive avg_data_in combinationally from ch_data of the latched channel until avg_data_valid=1.
REQ-025 On avg_data_valid in RUN, the block SHALL register avg_data_out and the channel index.
- Next state is PUBLISH, where result_valid=1 for exactly one cycle.
- Result latency: registered outputs valid the cycle after the strobe.
REQ-026 After PUBLISH, the block SHALL go to SELECT if enable=1, else to IDLE.
- last_ch updates to the published channel.
REQ-027 enable falling during CLEAR or RUN SHALL NOT abort the current channel; it completes through PUBLISH, then goes to IDLE.
REQ-028 avg_data_valid outside RUN SHALL be ignored.
REQ-029 In all states except RUN, avg_run SHALL be 0 and avg_data_in SHALL be 0.
REQ-030 Mask changes SHALL take effect only at the next SELECT.
REQ-031 A single enabled channel SHALL be serviced back-to-back with no idle gap beyond SELECT and CLEAR.
REQ-032 last_ch SHALL wrap from N_CHANNELS-1 to 0.

Reset
REQ-033 While reset=1, the state SHALL be IDLE and all of the following SHALL be 0: last_ch = N_CHANNELS-1 (so the first search starts at channel 0), avg_run, avg_clear, avg_points, avg_data_in, result_data, result_channel, result_valid, busy, timeout_err.
REQ-034 Reset asserted mid-RUN SHALL force IDLE immediately (asynchronously), and no result SHALL be published.

Configuration
REQ-035 Macro AVG_SCHED_TIMEOUT_EN, when defined, SHALL add output timeout_err, 1 bit, and a RUN cycle counter.
- When the counter reaches TIMEOUT_CYCLES, the block goes to SELECT with no publish and sets timeout_err.
- timeout_err is sticky until reset.
REQ-036 Without AVG_SCHED_TIMEOUT_EN, the port and counter SHALL be absent, and RUN SHALL wait indefinitely.

Verification
REQ-037 Bench SHALL cover:
- mask=4'b1011, all points=16, averager model with 16-cycle strobe -> results published for channels 0,1,3,0,1,3; each preceded by one avg_clear pulse.
- Channel 2 points=0, mask=4'b1111 -> channel 2 never selected, order 0,1,3.
- ch_data[0]=-323 constant, points=16 -> result_data=-323, result_channel=0.
- enable dropped in the 5th RUN cycle -> that channel publishes, then busy=0 in IDLE.
- reset pulsed mid-RUN -> all outputs 0 in the same cycle, no result_valid afterward.
- With AVG_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, avg_data_valid held low -> timeout_err=1 after 64 RUN cycles, next channel selected, no result_valid.
